pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives the stall, flush and bubble controls of the inter-stage registers, including the MEM/WB register. It selects EX-stage operand forwarding and sequences multi-cycle DRAM accesses with a req/ack handshake and a timeout. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/fwd_unit.sv | 27 ++
 rtl/pipeline_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the 5-stage pipeline control logic.
package pipe_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFault   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        WdSelAlu  = 2'b00,
        WdSelDram = 2'b01,
        WdSelPc4  = 2'b10
    } wd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand bypass select for one source register; MEM result beats WB.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] i_ex_rs,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_we,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_wb_we,
    output logic [1:0]      o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        // x0 is hardwired zero and must never be bypassed
        if (i_ex_rs != '0) begin
            if (i_mem_we && (i_mem_rd == i_ex_rs)) begin
                o_sel = FWD_MEM;
            end else if (i_wb_we && (i_wb_rd == i_ex_rs)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, DRAM req/ack with timeout,
// and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned RA_W        = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RA_W-1:0]  i_id_rs1,
    input  logic [RA_W-1:0]  i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [RA_W-1:0]  i_ex_rs1,
    input  logic [RA_W-1:0]  i_ex_rs2,
    input  logic [RA_W-1:0]  i_ex_rd,
    input  logic             i_ex_RF_WE,
    input  logic             i_ex_is_load,
    input  logic             i_ex_branch_taken,
    input  logic [RA_W-1:0]  i_mem_rd,
    input  logic             i_mem_RF_WE,
    input  logic             i_mem_req,
    input  logic             i_dram_ack,
    input  logic [RA_W-1:0]  i_wb_rd,
    input  logic             i_wb_RF_WE,
    output logic             o_dram_req,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_mem_wb_bubble,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_e            r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_mem_fault;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_req;
    logic w_load_use;
    logic w_hold;
    logic w_eval;
    logic w_lu_stall;

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .i_ex_rs  (i_ex_rs1),
        .i_mem_rd (i_mem_rd),
        .i_mem_we (i_mem_RF_WE),
        .i_wb_rd  (i_wb_rd),
        .i_wb_we  (i_wb_RF_WE),
        .o_sel    (o_fwd_a_sel)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .i_ex_rs  (i_ex_rs2),
        .i_mem_rd (i_mem_rd),
        .i_mem_we (i_mem_RF_WE),
        .i_wb_rd  (i_wb_rd),
        .i_wb_we  (i_wb_RF_WE),
        .o_sel    (o_fwd_b_sel)
    );

    // Gating with reset lets dram_req and the wait stalls fall immediately on rst.
    assign w_req = i_mem_req & ~i_rst;

    assign w_load_use = i_ex_is_load && i_ex_RF_WE && (i_ex_rd != '0) &&
                        ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        o_dram_req = 1'b0;
        w_hold     = 1'b0;
        w_eval     = 1'b0;
        unique case (r_state)
            StRun: begin
                o_dram_req = w_req;
                w_hold     = w_req && !i_dram_ack;
                w_eval     = !w_hold;
            end
            StMemWait: begin
                // The ack cycle releases the pipe, so hazards must be honoured there too.
                o_dram_req = 1'b1;
                w_hold     = !i_dram_ack;
                w_eval     = i_dram_ack;
            end
            StFault: begin
                w_hold = 1'b1;
            end
            default: begin
                w_hold = 1'b1;
            end
        endcase
    end

    assign w_lu_stall      = w_eval && !i_ex_branch_taken && w_load_use;
    assign o_pc_stall      = w_hold | w_lu_stall;
    assign o_if_id_stall   = w_hold | w_lu_stall;
    assign o_if_id_flush   = w_eval && i_ex_branch_taken;
    assign o_id_ex_stall   = w_hold;
    assign o_id_ex_flush   = w_eval && (i_ex_branch_taken || w_load_use);
    assign o_ex_mem_stall  = w_hold;
    assign o_mem_wb_bubble = w_hold;
    assign o_mem_fault     = r_mem_fault;
    assign o_stall_cnt     = r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_req && !i_dram_ack) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= '0;
                    end
                end
                StMemWait: begin
                    if (i_dram_ack) begin
                        r_state    <= StRun;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        r_state     <= StFault;
                        r_mem_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                StFault: begin
                    r_mem_fault <= 1'b1;
                end
                default: begin
                    r_state <= StFault;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (o_pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: single-cycle vector table plus DRAM wait, timeout and reset sequences.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_load;
        logic       br;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic       mem_req;
        logic       ack;
        logic [4:0] wb_rd;
        logic       wb_we;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [12:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] exp;
        logic [31:0] cnt;
        logic [3:0]  cnt_sat;
    } sb_t;

    // control bits: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    // ex_mem_stall, mem_wb_bubble
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_STALLS = 7'b1101011;
    localparam logic [6:0] C_LU     = 7'b1100100;
    localparam logic [6:0] C_BR     = 7'b0010100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, ex_we, ex_load, br, mem_we, mem_req, ack, wb_we;

    logic        dram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_bubble, mem_fault;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

    logic        s_dram_req, s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall;
    logic        s_id_ex_flush, s_ex_mem_stall, s_mem_wb_bubble, s_mem_fault;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt;

    pipeline_ctrl #(.RA_W(5), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
        .i_ex_RF_WE(ex_we), .i_ex_is_load(ex_load), .i_ex_branch_taken(br),
        .i_mem_rd(mem_rd), .i_mem_RF_WE(mem_we), .i_mem_req(mem_req), .i_dram_ack(ack),
        .i_wb_rd(wb_rd), .i_wb_RF_WE(wb_we),
        .o_dram_req(dram_req), .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall),
        .o_if_id_flush(if_id_flush), .o_id_ex_stall(id_ex_stall),
        .o_id_ex_flush(id_ex_flush), .o_ex_mem_stall(ex_mem_stall),
        .o_mem_wb_bubble(mem_wb_bubble), .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b),
        .o_mem_fault(mem_fault), .o_stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.RA_W(5), .MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
        .i_ex_RF_WE(ex_we), .i_ex_is_load(ex_load), .i_ex_branch_taken(br),
        .i_mem_rd(mem_rd), .i_mem_RF_WE(mem_we), .i_mem_req(mem_req), .i_dram_ack(ack),
        .i_wb_rd(wb_rd), .i_wb_RF_WE(wb_we),
        .o_dram_req(s_dram_req), .o_pc_stall(s_pc_stall), .o_if_id_stall(s_if_id_stall),
        .o_if_id_flush(s_if_id_flush), .o_id_ex_stall(s_id_ex_stall),
        .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_stall(s_ex_mem_stall),
        .o_mem_wb_bubble(s_mem_wb_bubble), .o_fwd_a_sel(s_fwd_a), .o_fwd_b_sel(s_fwd_b),
        .o_mem_fault(s_mem_fault), .o_stall_cnt(s_stall_cnt)
    );

    vec_t        tbl[$];
    sb_t         sbq[$];
    sb_t         sb;
    in_t         cur;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_cnt;
    logic [3:0]  m_sat;

    function automatic logic [12:0] e(logic dreq, logic [6:0] ctl, logic [1:0] fa,
                                      logic [1:0] fb, logic flt);
        return {dreq, ctl, fa, fb, flt};
    endfunction

    function automatic logic [12:0] got();
        return {dram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_bubble, fwd_a, fwd_b, mem_fault};
    endfunction

    task automatic chk(string n, logic [31:0] g, logic [31:0] x);
        total++;
        if (g !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, g, x);
        end
    endtask

    task automatic drive_in(in_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
        id_rs1_used = v.id_rs1_used; id_rs2_used = v.id_rs2_used;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        ex_we = v.ex_we; ex_load = v.ex_load; br = v.br;
        mem_rd = v.mem_rd; mem_we = v.mem_we; mem_req = v.mem_req; ack = v.ack;
        wb_rd = v.wb_rd; wb_we = v.wb_we;
    endtask

    task automatic add(string n, logic [12:0] x);
        tbl.push_back('{name: n, in: cur, exp: x});
    endtask

    // One cycle: drive cur, queue the expectation, check at negedge, advance the count model.
    task automatic step(string n, logic [12:0] x);
        drive_in(cur);
        sbq.push_back('{name: n, exp: x, cnt: m_cnt, cnt_sat: m_sat});
        @(negedge clk);
        sb = sbq.pop_front();
        chk(sb.name, {19'd0, got()}, {19'd0, sb.exp});
        chk({sb.name, "_cnt"}, stall_cnt, sb.cnt);
        chk({sb.name, "_sat"}, {28'd0, s_stall_cnt}, {28'd0, sb.cnt_sat});
        if (x[11]) begin
            if (m_cnt != 32'hffff_ffff) m_cnt++;
            if (m_sat != 4'hf) m_sat++;
        end
        @(posedge clk);
        #1;
    endtask

    // Asserted mid-cycle so outputs are checked before any clock edge sees reset.
    task automatic reset_seq(logic mreq);
        cur = '0;
        cur.mem_req = mreq;
        drive_in(cur);
        rst = 1'b1;
        #2;
        chk("rst_out", {19'd0, got()}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_sat", {28'd0, s_stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = '0;
        drive_in(cur);
        m_cnt = '0;
        m_sat = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        cur = '0;
        drive_in(cur);
        m_cnt = '0;
        m_sat = '0;
        #1;
        reset_seq(1'b0);

        cur = '0; add("idle", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_rs1 = 5; cur.mem_rd = 5; cur.mem_we = 1; cur.wb_rd = 5; cur.wb_we = 1;
        add("fwd_mem", e(0, C_NONE, FWD_MEM, FWD_RF, 0));
        cur.mem_we = 0; add("fwd_wb", e(0, C_NONE, FWD_WB, FWD_RF, 0));
        cur = '0; cur.mem_rd = 0; cur.mem_we = 1; cur.wb_we = 1;
        add("fwd_zero", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_rs1 = 2; cur.wb_rd = 2; cur.wb_we = 1;
        cur.ex_rs2 = 7; cur.mem_rd = 7; cur.mem_we = 1;
        add("fwd_b", e(0, C_NONE, FWD_WB, FWD_MEM, 0));
        cur = '0; cur.ex_rs1 = 9; cur.ex_rs2 = 9; cur.mem_rd = 9; cur.wb_rd = 9;
        add("fwd_nowe", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_load = 1; cur.ex_we = 1; cur.ex_rd = 3; cur.id_rs2 = 3;
        cur.id_rs2_used = 1;
        add("lu_rs2", e(0, C_LU, FWD_RF, FWD_RF, 0));
        cur.br = 1; add("lu_br", e(0, C_BR, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_load = 1; cur.ex_we = 1; cur.ex_rd = 3; cur.id_rs1 = 3;
        add("lu_unused", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_load = 1; cur.ex_we = 1; cur.id_rs1_used = 1;
        add("lu_rd0", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_load = 1; cur.ex_rd = 3; cur.id_rs1 = 3; cur.id_rs1_used = 1;
        add("lu_nowe", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur.ex_load = 0; cur.ex_we = 1; add("lu_noload", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ex_load = 1; cur.ex_we = 1; cur.ex_rd = 8; cur.id_rs1 = 8;
        cur.id_rs1_used = 1;
        add("lu_rs1", e(0, C_LU, FWD_RF, FWD_RF, 0));
        cur = '0; cur.br = 1; add("branch", e(0, C_BR, FWD_RF, FWD_RF, 0));
        cur = '0; cur.mem_req = 1; cur.ack = 1; add("zero_wait", e(1, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.ack = 1; add("spurious_ack", e(0, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; cur.mem_req = 1; cur.ack = 1; cur.br = 1;
        add("zw_branch", e(1, C_BR, FWD_RF, FWD_RF, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cur = tbl[i].in;
            step(tbl[i].name, tbl[i].exp);
        end

        // DRAM access acked on the fourth request cycle; branch during the wait is held off
        cur = '0; cur.mem_req = 1;
        step("dw_req", e(1, C_STALLS, FWD_RF, FWD_RF, 0));
        cur.br = 1; step("dw_wait_br", e(1, C_STALLS, FWD_RF, FWD_RF, 0));
        cur.br = 0; step("dw_wait", e(1, C_STALLS, FWD_RF, FWD_RF, 0));
        cur.ack = 1; step("dw_ack", e(1, C_NONE, FWD_RF, FWD_RF, 0));
        cur = '0; step("dw_run", e(0, C_NONE, FWD_RF, FWD_RF, 0));

        // Timeout: one RUN request cycle plus 16 MEM_WAIT cycles, then FAULT
        reset_seq(1'b0);
        cur = '0; cur.mem_req = 1;
        step("to_req", e(1, C_STALLS, FWD_RF, FWD_RF, 0));
        for (int i = 0; i < 16; i++) begin
            step($sformatf("to_wait%0d", i), e(1, C_STALLS, FWD_RF, FWD_RF, 0));
        end
        step("to_fault", e(0, C_STALLS, FWD_RF, FWD_RF, 1));
        cur.ack = 1; step("to_fault_ack", e(0, C_STALLS, FWD_RF, FWD_RF, 1));
        cur.ack = 0; cur.br = 1;
        cur.ex_rs1 = 4; cur.mem_rd = 4; cur.mem_we = 1;
        cur.ex_rs2 = 6; cur.wb_rd = 6; cur.wb_we = 1;
        step("to_fault_fwd", e(0, C_STALLS, FWD_MEM, FWD_WB, 1));
        step("to_fault_cnt", e(0, C_STALLS, FWD_MEM, FWD_WB, 1));

        reset_seq(1'b1);
        cur = '0; step("post_rst", e(0, C_NONE, FWD_RF, FWD_RF, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
